// File: rtl/lsu_prf_wb_arb_mp.sv
// rtl/lsu_prf_wb_arb_mp.sv - LSU writeback arbiter: SRC_COUNT L1D sources plus one bus source onto WB_PORTS PRF write ports
module lsu_prf_wb_arb_mp #(
  parameter int SRC_COUNT          = 2,
  parameter int WB_PORTS           = 1,
  parameter int FIFO_DEPTH         = 4,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int XLEN               = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  input  logic [SRC_COUNT-1:0]                     l1d_wb_vld_i,
  input  logic [SRC_COUNT*PHY_REG_ADDR_WIDTH-1:0]  l1d_wb_rd_addr_i,
  input  logic [SRC_COUNT*XLEN-1:0]                l1d_wb_data_i,
  output logic                                     wb_arb_rdy_o,
  input  logic                                     bus_wb_vld_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]            bus_wb_rd_addr_i,
  input  logic [XLEN-1:0]                          bus_wb_data_i,
  output logic                                     wb_arb_bus_rdy_o,
  output logic [WB_PORTS-1:0]                      prf_wb_vld_o,
  output logic [WB_PORTS*PHY_REG_ADDR_WIDTH-1:0]   prf_wb_rd_addr_o,
  output logic [WB_PORTS*XLEN-1:0]                 prf_wb_data_o,
  output logic [$clog2(FIFO_DEPTH):0]              fifo_cnt_o,
  output logic                                     ovf_err_o
);

  localparam int PRA = PHY_REG_ADDR_WIDTH;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int EW  = PRA + XLEN;

  // Overflow FIFO entries are {rd, data}
  logic [EW-1:0]  r_fifo [FIFO_DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_cnt;
  logic           r_rdy;
  logic           r_ovf;

  logic                 w_block;
  logic                 w_bus_rdy;
  logic                 w_ovf;
  logic [SRC_COUNT-1:0] w_gnt;
  int                   w_gnt_port [SRC_COUNT];
  logic [SRC_COUNT-1:0] w_enq_en;
  logic [AW-1:0]        w_enq_slot [SRC_COUNT];
  logic [AW-1:0]        w_idx;
  int                   w_used;
  int                   w_ndeq;
  int                   w_nenq;
  int                   w_nreq;
  int                   w_space;
  int                   w_cnt_next;

  // Slot allocation: FIFO head first, then live L1D results in source order, then the bus
  always_comb begin
    prf_wb_vld_o     = '0;
    prf_wb_rd_addr_o = '0;
    prf_wb_data_o    = '0;
    w_gnt            = '0;
    w_enq_en         = '0;
    for (int k = 0; k < SRC_COUNT; k++) begin
      w_gnt_port[k] = 0;
      w_enq_slot[k] = '0;
    end
    w_idx      = '0;
    w_bus_rdy  = 1'b0;
    w_ovf      = 1'b0;
    w_used     = 0;
    w_ndeq     = 0;
    w_nenq     = 0;
    w_nreq     = 0;
    w_block    = rst | flush;
    w_space    = FIFO_DEPTH - int'(r_cnt);

    if (!w_block) begin
      // Oldest buffered results own the lowest ports
      for (int p = 0; p < WB_PORTS; p++) begin
        if (p < int'(r_cnt)) begin
          w_idx = AW'((int'(r_head) + p) % FIFO_DEPTH);
          prf_wb_vld_o[p]               = 1'b1;
          prf_wb_rd_addr_o[p*PRA +: PRA] = r_fifo[w_idx][EW-1:XLEN];
          prf_wb_data_o[p*XLEN +: XLEN]  = r_fifo[w_idx][XLEN-1:0];
          w_used = w_used + 1;
          w_ndeq = w_ndeq + 1;
        end
      end
      w_space = w_space + w_ndeq;

      // New results go direct only once the FIFO is fully drained this cycle; the rest queue up
      for (int k = 0; k < SRC_COUNT; k++) begin
        if (l1d_wb_vld_i[k]) begin
          if ((w_used < WB_PORTS) && (w_ndeq == int'(r_cnt))) begin
            w_gnt[k]      = 1'b1;
            w_gnt_port[k] = w_used;
            w_used        = w_used + 1;
          end else begin
            w_nreq = w_nreq + 1;
            if (w_nenq < w_space) begin
              w_enq_en[k]   = 1'b1;
              w_enq_slot[k] = AW'((int'(r_tail) + w_nenq) % FIFO_DEPTH);
              w_nenq        = w_nenq + 1;
            end else begin
              w_ovf = 1'b1;
            end
          end
        end
      end

      w_bus_rdy = (w_used < WB_PORTS) && (r_cnt == '0) && (w_nreq == 0);

      for (int p = 0; p < WB_PORTS; p++) begin
        for (int k = 0; k < SRC_COUNT; k++) begin
          if (w_gnt[k] && (w_gnt_port[k] == p)) begin
            prf_wb_vld_o[p]               = 1'b1;
            prf_wb_rd_addr_o[p*PRA +: PRA] = l1d_wb_rd_addr_i[k*PRA +: PRA];
            prf_wb_data_o[p*XLEN +: XLEN]  = l1d_wb_data_i[k*XLEN +: XLEN];
          end
        end
        if (w_bus_rdy && bus_wb_vld_i && (w_used == p)) begin
          prf_wb_vld_o[p]               = 1'b1;
          prf_wb_rd_addr_o[p*PRA +: PRA] = bus_wb_rd_addr_i;
          prf_wb_data_o[p*XLEN +: XLEN]  = bus_wb_data_i;
        end
      end
    end
    w_cnt_next = int'(r_cnt) - w_ndeq + w_nenq;
  end

  // Pointer, occupancy, ready and sticky error state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_rdy  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_rdy  <= 1'b1;
    end else begin
      r_head <= AW'((int'(r_head) + w_ndeq) % FIFO_DEPTH);
      r_tail <= AW'((int'(r_tail) + w_nenq) % FIFO_DEPTH);
      r_cnt  <= CW'(w_cnt_next);
      r_rdy  <= (FIFO_DEPTH - w_cnt_next) >= SRC_COUNT;
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // FIFO storage write, several sources may enqueue in the same cycle
  always_ff @(posedge clk) begin
    for (int k = 0; k < SRC_COUNT; k++) begin
      if (w_enq_en[k]) begin
        r_fifo[w_enq_slot[k]] <= {l1d_wb_rd_addr_i[k*PRA +: PRA], l1d_wb_data_i[k*XLEN +: XLEN]};
      end
    end
  end

  assign wb_arb_rdy_o     = r_rdy & ~rst;
  assign wb_arb_bus_rdy_o = w_bus_rdy;
  assign fifo_cnt_o       = r_cnt;
  assign ovf_err_o        = r_ovf;

endmodule
